// File: rtl/wave_gen.sv
// -----------------------------------------------------------------------------
// wave_gen
//   A sine/cosine generator. Each rising LATCH strobe (a 0->1 change seen
//   across CLK edges) adds PHASE_INC to a 16-bit phase accumulator. The top
//   eight accumulator bits index a 256-point sine table. The table is built
//   by symmetry from a 65-entry quarter-wave ROM.
//
//   Ports
//     CLK     in   1   system clock, rising edge
//     RST_N   in   1   asynchronous active-low reset
//     LATCH   in   1   sample strobe, edge-detected inside the block
//     DATA_L  out 16   signed sine sample, S(PH[15:8])
//     DATA_R  out 16   signed cosine sample, S(PH[15:8] + 64)
//
//   Timing: an edge sees LATCH=1 and updates PH. The next edge registers the
//   table lookup of the new PH onto DATA_L and DATA_R.
// -----------------------------------------------------------------------------
module wave_gen #(
   parameter logic [15:0] PHASE_INC = 16'd256
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        LATCH,
   output logic [15:0] DATA_L,
   output logic [15:0] DATA_R
);

   logic [15:0] ph;
   logic        latch_d;
   logic        latch_evt;
   logic [7:0]  idx_l;
   logic [7:0]  idx_r;
   logic [15:0] sine_l;
   logic [15:0] sine_r;

   // Quarter-wave ROM: round(32767*sin(2*pi*k/256)), k = 0..64
   function automatic logic [15:0] quarter(input logic [6:0] k);
      logic [15:0] v;
      v = '0;
      case (k)
         7'd0:  v = 16'd0;     7'd1:  v = 16'd804;   7'd2:  v = 16'd1608;
         7'd3:  v = 16'd2410;  7'd4:  v = 16'd3212;  7'd5:  v = 16'd4011;
         7'd6:  v = 16'd4808;  7'd7:  v = 16'd5602;  7'd8:  v = 16'd6393;
         7'd9:  v = 16'd7179;  7'd10: v = 16'd7962;  7'd11: v = 16'd8739;
         7'd12: v = 16'd9512;  7'd13: v = 16'd10278; 7'd14: v = 16'd11039;
         7'd15: v = 16'd11793; 7'd16: v = 16'd12539; 7'd17: v = 16'd13279;
         7'd18: v = 16'd14010; 7'd19: v = 16'd14732; 7'd20: v = 16'd15446;
         7'd21: v = 16'd16151; 7'd22: v = 16'd16846; 7'd23: v = 16'd17530;
         7'd24: v = 16'd18204; 7'd25: v = 16'd18868; 7'd26: v = 16'd19519;
         7'd27: v = 16'd20159; 7'd28: v = 16'd20787; 7'd29: v = 16'd21403;
         7'd30: v = 16'd22005; 7'd31: v = 16'd22594; 7'd32: v = 16'd23170;
         7'd33: v = 16'd23731; 7'd34: v = 16'd24279; 7'd35: v = 16'd24811;
         7'd36: v = 16'd25329; 7'd37: v = 16'd25832; 7'd38: v = 16'd26319;
         7'd39: v = 16'd26790; 7'd40: v = 16'd27245; 7'd41: v = 16'd27683;
         7'd42: v = 16'd28105; 7'd43: v = 16'd28510; 7'd44: v = 16'd28898;
         7'd45: v = 16'd29268; 7'd46: v = 16'd29621; 7'd47: v = 16'd29956;
         7'd48: v = 16'd30273; 7'd49: v = 16'd30571; 7'd50: v = 16'd30852;
         7'd51: v = 16'd31113; 7'd52: v = 16'd31356; 7'd53: v = 16'd31580;
         7'd54: v = 16'd31785; 7'd55: v = 16'd31971; 7'd56: v = 16'd32137;
         7'd57: v = 16'd32285; 7'd58: v = 16'd32412; 7'd59: v = 16'd32521;
         7'd60: v = 16'd32609; 7'd61: v = 16'd32678; 7'd62: v = 16'd32728;
         7'd63: v = 16'd32757; 7'd64: v = 16'd32767;
         default: v = '0;
      endcase
      return v;
   endfunction

   // Full-wave sine by symmetry. Bit 7 selects the negative half. The lower
   // seven bits fold 65..127 back onto 63..1.
   function automatic logic [15:0] sine(input logic [7:0] i);
      logic [6:0]  low;
      logic [6:0]  k;
      logic [7:0]  mirror;
      logic [15:0] mag;
      low    = i[6:0];
      mirror = 8'd128 - {1'b0, low};
      k      = (low <= 7'd64) ? low : mirror[6:0];
      mag    = quarter(k);
      // mag never exceeds 32767, so the negation bottoms out at 16'h8001
      return i[7] ? (~mag + 16'd1) : mag;
   endfunction

   assign latch_evt = LATCH & ~latch_d;
   assign idx_l     = ph[15:8];
   assign idx_r     = ph[15:8] + 8'd64;

   always_comb begin
      sine_l = sine(idx_l);
      sine_r = sine(idx_r);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         latch_d <= 1'b0;
         ph      <= '0;
      end else begin
         latch_d <= LATCH;
         if (latch_evt)
            ph <= ph + PHASE_INC;
      end
   end

   // Outputs are re-registered every edge. When PH has not moved they reload
   // the same value, which leaves them holding.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DATA_L <= 16'h0000;
         DATA_R <= 16'h7FFF;
      end else begin
         DATA_L <= sine_l;
         DATA_R <= sine_r;
      end
   end

endmodule

// File: tb/tb_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_wave_gen
//   Directed bench for wave_gen. It runs two instances: the default
//   PHASE_INC of 256, and PHASE_INC = 16'h4000. The instances share the clock
//   and reset but have separate strobes. Inputs change on the falling edge,
//   and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_wave_gen;

   logic        clk;
   logic        rst_n;
   logic        latch;
   logic        latch4;
   logic [15:0] data_l;
   logic [15:0] data_r;
   logic [15:0] data_l4;
   logic [15:0] data_r4;

   int unsigned tests;
   int unsigned fails;

   wave_gen dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .LATCH  (latch),
      .DATA_L (data_l),
      .DATA_R (data_r)
   );

   wave_gen #(.PHASE_INC(16'h4000)) dut4 (
      .CLK    (clk),
      .RST_N  (rst_n),
      .LATCH  (latch4),
      .DATA_L (data_l4),
      .DATA_R (data_r4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)",
                tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle pulses, two cycles apart. Each call ends at a falling edge.
   // The last advance of PH has happened by then, but its output update has
   // not.
   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) latch = 1'b1;
         @(negedge clk) latch = 1'b0;
      end
   endtask

   task automatic pulse4;
      @(negedge clk) latch4 = 1'b1;
      @(negedge clk) latch4 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      rst_n  = 1'b0;
      latch  = 1'b0;
      latch4 = 1'b0;

      // Reset state
      cycles(3);
      check("reset_l", data_l, 16'd0);
      check("reset_r", data_r, 16'd32767);
      check("reset_l4", data_l4, 16'd0);
      check("reset_r4", data_r4, 16'd32767);
      @(negedge clk) rst_n = 1'b1;
      cycles(2);

      // Single step: outputs hold after the first edge and update after the
      // second.
      @(negedge clk) latch = 1'b1;
      @(negedge clk) latch = 1'b0;
      check("step_hold_l", data_l, 16'd0);
      check("step_hold_r", data_r, 16'd32767);
      cycles(1);
      check("step_l", data_l, 16'd804);
      check("step_r", data_r, 16'd32757);

      // Quadrant points
      pulses(63); cycles(1);
      check("q64_l", data_l, 16'd32767);
      check("q64_r", data_r, 16'd0);
      pulses(64); cycles(1);
      check("q128_l", data_l, 16'd0);
      check("q128_r", data_r, 16'h8001);
      pulses(64); cycles(1);
      check("q192_l", data_l, 16'h8001);
      check("q192_r", data_r, 16'd0);
      pulses(64); cycles(1);
      check("q256_l", data_l, 16'd0);
      check("q256_r", data_r, 16'd32767);

      // Held strobe counts once. Two further pulses are 200 ns apart.
      @(negedge clk) latch = 1'b1;
      cycles(9);
      @(negedge clk) latch = 1'b0;
      cycles(2);
      check("held_l", data_l, 16'd804);
      cycles(5);
      check("held_still_l", data_l, 16'd804);
      @(negedge clk) latch = 1'b1;
      @(negedge clk) latch = 1'b0;
      cycles(18);
      @(negedge clk) latch = 1'b1;
      @(negedge clk) latch = 1'b0;
      cycles(1);
      check("held3_l", data_l, 16'd2410);
      check("held3_r", data_r, 16'd32678);

      // Reset back to phase 0, then 40 pulses
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      pulses(40); cycles(1);
      check("p40_l", data_l, 16'd27245);
      check("p40_r", data_r, 16'd18204);

      // Asynchronous reset between edges
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_l", data_l, 16'd0);
      check("async_r", data_r, 16'd32767);

      // LATCH already high at reset release counts on the first edge
      latch = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("relhigh_hold_l", data_l, 16'd0);
      @(negedge clk);
      check("relhigh_l", data_l, 16'd804);
      latch = 1'b0;

      // PHASE_INC = 16'h4000 steps a quarter turn per event and wraps to 0
      pulse4;
      check("inc1_l", data_l4, 16'd32767);
      check("inc1_r", data_r4, 16'd0);
      pulse4;
      check("inc2_l", data_l4, 16'd0);
      check("inc2_r", data_r4, 16'h8001);
      pulse4;
      check("inc3_l", data_l4, 16'h8001);
      check("inc3_r", data_r4, 16'd0);
      pulse4;
      check("inc4_l", data_l4, 16'd0);
      check("inc4_r", data_r4, 16'd32767);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
